differentiate: RTL and testbench



---
 rtl/differentiate_pkg.sv | 17 +
 rtl/differentiate_if.sv | 21 ++
 rtl/differentiate_delay_line.sv | 25 ++
 rtl/differentiate.sv | 57 +++++
 tb/tb_differentiate.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/differentiate_pkg.sv
// differentiate_pkg: shared constants and helper functions for the differentiate block
package differentiate_pkg;

    // Ceil-log2 with a floor of one bit. Counters sized with it always have at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Legal configurations need at least two samples per line and a window of 1..LINE_LEN.
    function automatic bit params_ok(input int line_len, input int win);
        return (line_len >= 2) && (win >= 1) && (win <= line_len);
    endfunction

endpackage

// File: rtl/differentiate_if.sv
// differentiate_if: stream bundle carrying prefix sums in and differenced values out
interface differentiate_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_frame_start;
    logic [BIT_WIDTH-1:0] in_value;
    logic                 out_valid;
    logic                 out_line_start;
    logic [BIT_WIDTH-1:0] out_value;

    modport master (
        output in_valid, in_frame_start, in_value,
        input  out_valid, out_line_start, out_value
    );

    modport slave (
        input  in_valid, in_frame_start, in_value,
        output out_valid, out_line_start, out_value
    );
endinterface

// File: rtl/differentiate_delay_line.sv
// delay_line: DEPTH-stage enabled shift register with synchronous clear
module delay_line #(
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 1
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] in_value,
    output logic [BIT_WIDTH-1:0] out_value
);
    logic [BIT_WIDTH-1:0] stage [DEPTH];

    // Shift one position per enabled cycle; the last stage is the value DEPTH pushes ago.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (enable) begin
            stage[0] <= in_value;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_value = stage[DEPTH-1];
endmodule

// File: rtl/differentiate.sv
// differentiate: recovers S[x] - S[x-WIN] from a raster stream of per-line prefix sums
module differentiate
    import differentiate_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int LINE_LEN  = 640,
    parameter int WIN       = 1
) (
    input logic          clock,
    input logic          n_rst,
    differentiate_if.slave bus
);
    localparam int XW = clog2(LINE_LEN);

    generate
        if (!params_ok(LINE_LEN, WIN)) begin : g_bad_params
            $error("differentiate: need LINE_LEN >= 2 and 1 <= WIN <= LINE_LEN");
        end
    endgenerate

    logic [XW-1:0]        x;
    logic [XW-1:0]        x_cur;
    logic [BIT_WIDTH-1:0] hist_out;
    logic [BIT_WIDTH-1:0] sub;

    delay_line #(
        .BIT_WIDTH(BIT_WIDTH),
        .DEPTH    (WIN)
    ) u_hist (
        .clock    (clock),
        .n_rst    (n_rst),
        .enable   (bus.in_valid),
        .in_value (bus.in_value),
        .out_value(hist_out)
    );

    // A frame start pins this sample to x=0; history from earlier lines is masked by the x test.
    assign x_cur = bus.in_frame_start ? '0 : x;
    assign sub   = (int'(x_cur) >= WIN) ? hist_out : '0;

    // Register the difference and line-start flag; bubbles leave everything but out_valid held.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            x                  <= '0;
            bus.out_valid      <= 1'b0;
            bus.out_line_start <= 1'b0;
            bus.out_value      <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                x                  <= (x_cur == XW'(LINE_LEN - 1)) ? '0 : x_cur + 1'b1;
                bus.out_value      <= bus.in_value - sub;
                bus.out_line_start <= (x_cur == '0);
            end
        end
    end
endmodule

// File: tb/tb_differentiate.sv
// tb_differentiate: four configurations driven in parallel against a line-history reference model
module tb_differentiate;
    logic        clock = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_frame_start;
    logic [15:0] in_value;

    int n_checks = 0;
    int n_fail   = 0;

    // Configurations: A(16,8,1) B(16,8,2) C(16,4,2) D(8,8,1) as (BIT_WIDTH, LINE_LEN, WIN)
    int cfg_w [4] = '{16, 16, 16, 8};
    int cfg_l [4] = '{8, 8, 4, 8};
    int cfg_n [4] = '{1, 2, 2, 1};

    int got_val [4];
    int got_ls  [4];
    int got_vld [4];

    int mx     [4];
    int line_s [4][8];
    int ev     [4];
    int els    [4];
    int evld   [4];

    always #5 clock = ~clock;

    differentiate_if #(.BIT_WIDTH(16)) ia ();
    differentiate_if #(.BIT_WIDTH(16)) ib ();
    differentiate_if #(.BIT_WIDTH(16)) ic ();
    differentiate_if #(.BIT_WIDTH(8))  id ();

    assign ia.in_valid = in_valid;  assign ia.in_frame_start = in_frame_start;  assign ia.in_value = in_value;
    assign ib.in_valid = in_valid;  assign ib.in_frame_start = in_frame_start;  assign ib.in_value = in_value;
    assign ic.in_valid = in_valid;  assign ic.in_frame_start = in_frame_start;  assign ic.in_value = in_value;
    assign id.in_valid = in_valid;  assign id.in_frame_start = in_frame_start;  assign id.in_value = in_value[7:0];

    assign got_val[0] = int'(ia.out_value); assign got_ls[0] = int'(ia.out_line_start); assign got_vld[0] = int'(ia.out_valid);
    assign got_val[1] = int'(ib.out_value); assign got_ls[1] = int'(ib.out_line_start); assign got_vld[1] = int'(ib.out_valid);
    assign got_val[2] = int'(ic.out_value); assign got_ls[2] = int'(ic.out_line_start); assign got_vld[2] = int'(ic.out_valid);
    assign got_val[3] = int'(id.out_value); assign got_ls[3] = int'(id.out_line_start); assign got_vld[3] = int'(id.out_valid);

    differentiate #(.BIT_WIDTH(16), .LINE_LEN(8), .WIN(1)) dut_a (.clock(clock), .n_rst(n_rst), .bus(ia));
    differentiate #(.BIT_WIDTH(16), .LINE_LEN(8), .WIN(2)) dut_b (.clock(clock), .n_rst(n_rst), .bus(ib));
    differentiate #(.BIT_WIDTH(16), .LINE_LEN(4), .WIN(2)) dut_c (.clock(clock), .n_rst(n_rst), .bus(ic));
    differentiate #(.BIT_WIDTH(8),  .LINE_LEN(8), .WIN(1)) dut_d (.clock(clock), .n_rst(n_rst), .bus(id));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference model at the edge, then compare every DUT.
    task automatic step(input logic r, input logic v, input logic fs, input logic [15:0] s);
        int x, sv, sub, mask;
        n_rst = r; in_valid = v; in_frame_start = fs; in_value = s;
        @(posedge clock);
        for (int k = 0; k < 4; k++) begin
            mask = (1 << cfg_w[k]) - 1;
            if (!r) begin
                mx[k] = 0; ev[k] = 0; els[k] = 0; evld[k] = 0;
            end else begin
                evld[k] = int'(v);
                if (v) begin
                    x  = fs ? 0 : mx[k];
                    sv = int'(s) & mask;
                    line_s[k][x] = sv;
                    sub = (x >= cfg_n[k]) ? line_s[k][x - cfg_n[k]] : 0;
                    ev[k]  = (sv - sub) & mask;
                    els[k] = (x == 0) ? 1 : 0;
                    mx[k]  = (x + 1) % cfg_l[k];
                end
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("model_valid[%0d]", k), got_vld[k], evld[k]);
            check($sformatf("model_line_start[%0d]", k), got_ls[k], els[k]);
            check($sformatf("model_value[%0d]", k), got_val[k], ev[k]);
        end
    endtask

    int s1 [8] = '{3, 5, 5, 12, 20, 21, 30, 31};
    int e1 [8] = '{3, 2, 0, 7, 8, 1, 9, 1};
    int s2 [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
    int e2 [8] = '{1, 3, 5, 7, 9, 11, 13, 15};
    int s4 [8] = '{2, 4, 6, 8, 5, 6, 7, 8};
    int e4 [8] = '{2, 4, 4, 4, 5, 6, 2, 2};

    initial begin
        step(1'b0, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 4; k++) begin
            check("reset_valid", got_vld[k], 0);
            check("reset_value", got_val[k], 0);
            check("reset_line_start", got_ls[k], 0);
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, i == 0, 16'(s1[i]));
            check($sformatf("recover_value[%0d]", i), got_val[0], e1[i]);
            check($sformatf("recover_ls[%0d]", i), got_ls[0], (i == 0) ? 1 : 0);
            check($sformatf("recover_valid[%0d]", i), got_vld[0], 1);
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, i == 0, 16'(s2[i]));
            check($sformatf("window_value[%0d]", i), got_val[1], e2[i]);
        end

        step(1'b1, 1'b1, 1'b1, 16'd250);
        check("wrap_first", got_val[3], 250);
        step(1'b1, 1'b1, 1'b0, 16'd4);
        check("wrap_second", got_val[3], 10);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, i == 0, 16'(s4[i]));
            check($sformatf("line_value[%0d]", i), got_val[2], e4[i]);
            check($sformatf("line_ls[%0d]", i), got_ls[2], (i % 4 == 0) ? 1 : 0);
            step(1'b1, 1'b0, 1'b0, 16'($urandom));
            check($sformatf("bubble_valid[%0d]", i), got_vld[2], 0);
            check($sformatf("bubble_hold[%0d]", i), got_val[2], e4[i]);
            check($sformatf("bubble_ls_hold[%0d]", i), got_ls[2], (i % 4 == 0) ? 1 : 0);
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i == 0, 16'(100 + i));
        step(1'b0, 1'b1, 1'b0, 16'd55);
        check("rst_mid_valid", got_vld[0], 0);
        check("rst_mid_value", got_val[0], 0);
        step(1'b1, 1'b1, 1'b0, 16'd9);
        check("resync_value0", got_val[0], 9);
        check("resync_ls0", got_ls[0], 1);
        step(1'b1, 1'b1, 1'b0, 16'd10);
        check("resync_value1", got_val[0], 1);
        check("resync_ls1", got_ls[0], 0);
        step(1'b1, 1'b1, 1'b1, 16'd77);
        check("midline_fs_value", got_val[0], 77);
        check("midline_fs_ls", got_ls[0], 1);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(99) != 0, $urandom_range(9) < 7, $urandom_range(19) == 0, 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
